// File: rtl/instr_load_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// instr_load_pkg
// Shared types and constants for the instruction-memory load controller.
//   state_t         : controller FSM states (CHECK only reachable when the
//                     CHECKSUM_EN macro is defined)
//   BYTE_WIDTH      : bits per streamed byte
//   BYTES_PER_WORD  : bytes packed into one instruction
//   WORD_ADDR_SHIFT : word index -> byte address shift
// ----------------------------------------------------------------------------
package instr_load_pkg;

    localparam int BYTE_WIDTH      = 8;
    localparam int BYTES_PER_WORD  = 4;
    localparam int WORD_ADDR_SHIFT = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        CHECK = 3'd4
    } state_t;

endpackage

// File: rtl/instr_load_ctrl_packer.sv
// ----------------------------------------------------------------------------
// byte_word_packer
// Packs a little-endian byte stream into INSTR_WIDTH-bit words.
// Ports:
//   clk_i, rst_i   : clock, async active-high reset
//   clr_i          : restart at byte 0 (start of a new load)
//   xfer_i         : a byte is transferred this cycle
//   byte_i         : byte payload
//   word_o         : assembled word; the lane of the current byte index is
//                    taken straight from byte_i so the word is complete in
//                    the same cycle as its last byte
//   word_done_o    : last byte of a word is transferred this cycle
// ----------------------------------------------------------------------------
module byte_word_packer
    import instr_load_pkg::*;
#(
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   xfer_i,
    input  logic [BYTE_WIDTH-1:0]  byte_i,
    output logic [INSTR_WIDTH-1:0] word_o,
    output logic                   word_done_o
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [INSTR_WIDTH-1:0] asm_q, asm_d;

    always_comb begin
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        if (clr_i) begin
            byte_idx_d = '0;
        end else if (xfer_i) begin
            // 2-bit index wraps 3 -> 0 on its own
            byte_idx_d = byte_idx_q + 2'd1;
            asm_d[byte_idx_q*BYTE_WIDTH +: BYTE_WIDTH] = byte_i;
        end
    end

    always_comb begin
        word_o = asm_q;
        word_o[byte_idx_q*BYTE_WIDTH +: BYTE_WIDTH] = byte_i;
    end

    assign word_done_o = xfer_i && (byte_idx_q == LAST_IDX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byte_idx_q <= '0;
            asm_q      <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
        end
    end

endmodule

// File: rtl/instr_load_ctrl.sv
// ----------------------------------------------------------------------------
// instr_load_ctrl
// Boot/reload controller for the MIPS instruction memory. Receives bytes over
// a valid/ready handshake, packs them little-endian into instructions, writes
// them to consecutive word addresses while holding the CPU stalled, then
// pulses PcReset so execution restarts at address 0.
// Optional feature: define CHECKSUM_EN to require a trailing checksum byte
// (8-bit sum of all data bytes plus checksum must be 0 mod 256).
// Ports:
//   CLK, RST             : clock, async active-high reset
//   LoadStart            : begin a load (IDLE only), LoadWordCount sampled
//   ByteValid/ByteData   : byte source
//   ByteReady            : byte accepted this cycle when ByteValid
//   MemWriteEn/Address/Data : instruction-memory write port
//   CpuStall, PcReset    : CPU control
//   Busy, LoadError      : status (LoadError is sticky until a legal start)
// ----------------------------------------------------------------------------
module instr_load_ctrl
    import instr_load_pkg::*;
#(
    parameter int INSTR_WIDTH   = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_DEPTH     = 100,
    parameter int COUNT_WIDTH   = 7
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     LoadStart,
    input  logic [COUNT_WIDTH-1:0]   LoadWordCount,
    input  logic                     ByteValid,
    input  logic [BYTE_WIDTH-1:0]    ByteData,
    output logic                     ByteReady,
    output logic                     MemWriteEn,
    output logic [ADDRESS_WIDTH-1:0] MemWriteAddress,
    output logic [INSTR_WIDTH-1:0]   MemWriteData,
    output logic                     CpuStall,
    output logic                     PcReset,
    output logic                     Busy,
    output logic                     LoadError
);

    state_t                   state_q, state_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic [COUNT_WIDTH-1:0]   word_idx_q, word_idx_d;
    logic                     err_q, err_d;
    logic [INSTR_WIDTH-1:0]   data_q, data_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;

    logic                   xfer;
    logic                   pk_clr;
    logic                   pk_done;
    logic [INSTR_WIDTH-1:0] pk_word;
    logic                   count_bad;
    logic                   last_word;
    state_t                 after_last;

    assign xfer      = ByteValid && ByteReady;
    assign count_bad = (LoadWordCount == '0) ||
                       (LoadWordCount > COUNT_WIDTH'(MEM_DEPTH));
    assign last_word = (word_idx_q == count_q - COUNT_WIDTH'(1));

`ifdef CHECKSUM_EN
    logic [BYTE_WIDTH-1:0] sum_q, sum_d;
    logic [BYTE_WIDTH-1:0] cks_total;

    assign cks_total  = sum_q + ByteData;
    assign after_last = CHECK;

    always_comb begin
        sum_d = sum_q;
        if (state_q == IDLE && LoadStart && !count_bad) begin
            sum_d = '0;
        end else if (state_q == LOAD && xfer) begin
            sum_d = sum_q + ByteData;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) sum_q <= '0;
        else     sum_q <= sum_d;
    end
`else
    assign after_last = DONE;
`endif

    byte_word_packer #(
        .INSTR_WIDTH(INSTR_WIDTH)
    ) u_packer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .clr_i      (pk_clr),
        .xfer_i     (xfer && state_q == LOAD),
        .byte_i     (ByteData),
        .word_o     (pk_word),
        .word_done_o(pk_done)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        err_d      = err_q;
        data_d     = data_q;
        addr_d     = addr_q;
        pk_clr     = 1'b0;
        ByteReady  = 1'b0;
        MemWriteEn = 1'b0;
        PcReset    = 1'b0;

        case (state_q)
            IDLE: begin
                if (LoadStart) begin
                    if (count_bad) begin
                        err_d = 1'b1;
                    end else begin
                        err_d      = 1'b0;
                        count_d    = LoadWordCount;
                        word_idx_d = '0;
                        pk_clr     = 1'b1;
                        state_d    = LOAD;
                    end
                end
            end
            LOAD: begin
                ByteReady = 1'b1;
                if (pk_done) begin
                    // Capture data and address together so both hold
                    // steadily through WRITE and afterwards.
                    data_d  = pk_word;
                    addr_d  = ADDRESS_WIDTH'(word_idx_q) << WORD_ADDR_SHIFT;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                MemWriteEn = 1'b1;
                if (last_word) begin
                    state_d = after_last;
                end else begin
                    word_idx_d = word_idx_q + COUNT_WIDTH'(1);
                    state_d    = LOAD;
                end
            end
            DONE: begin
                PcReset = 1'b1;
                state_d = IDLE;
            end
`ifdef CHECKSUM_EN
            CHECK: begin
                ByteReady = 1'b1;
                if (ByteValid) begin
                    if (cks_total == '0) begin
                        state_d = DONE;
                    end else begin
                        // Bad image: leave the CPU stalled via LoadError.
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign MemWriteAddress = addr_q;
    assign MemWriteData    = data_q;
    assign Busy            = (state_q != IDLE);
    assign CpuStall        = (state_q != IDLE) || err_q;
    assign LoadError       = err_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            err_q      <= 1'b0;
            data_q     <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            err_q      <= err_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
        end
    end

endmodule

// File: tb/tb_instr_load_ctrl.sv
// ----------------------------------------------------------------------------
// tb_instr_load_ctrl
// Directed bench for instr_load_ctrl. A scoreboard of expected memory writes
// (address, little-endian word) is built from the byte image being sent; a
// single negedge monitor checks every write strobe, the stall/busy relation,
// ByteReady during writes, write spacing and PcReset placement. Tests also
// pin a few hand-computed literal words/addresses.
// ----------------------------------------------------------------------------
module tb_instr_load_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        LoadStart = 1'b0;
    logic [6:0]  LoadWordCount = '0;
    logic        ByteValid = 1'b0;
    logic [7:0]  ByteData = '0;
    logic        ByteReady, MemWriteEn, CpuStall, PcReset, Busy, LoadError;
    logic [31:0] MemWriteAddress, MemWriteData;

    instr_load_ctrl dut (
        .CLK            (CLK),
        .RST            (RST),
        .LoadStart      (LoadStart),
        .LoadWordCount  (LoadWordCount),
        .ByteValid      (ByteValid),
        .ByteData       (ByteData),
        .ByteReady      (ByteReady),
        .MemWriteEn     (MemWriteEn),
        .MemWriteAddress(MemWriteAddress),
        .MemWriteData   (MemWriteData),
        .CpuStall       (CpuStall),
        .PcReset        (PcReset),
        .Busy           (Busy),
        .LoadError      (LoadError)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [63:0] exp_q[$];
    logic [7:0]  img [0:399];
    logic [7:0]  model_sum;
    int          wr_cnt = 0, pc_cnt = 0, cyc = 0, last_we = 0;
    bit          have_prev = 0, prev_we = 0, mon_en = 0;
    logic [31:0] last_addr, last_data;

    always @(negedge CLK) begin
        if (mon_en) begin
            cyc++;
            chk(!(Busy && !CpuStall), "stall_when_busy", CpuStall, 1);
            if (MemWriteEn) begin
                chk(ByteReady == 1'b0, "ready_in_write", ByteReady, 0);
                chk(exp_q.size() > 0, "unexpected_write", MemWriteAddress, 0);
                if (exp_q.size() > 0) begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk({MemWriteAddress, MemWriteData} == e, "write_addr_data",
                        {MemWriteAddress, MemWriteData}, e);
                end
                if (have_prev)
                    chk(cyc - last_we >= 5, "write_spacing", cyc - last_we, 5);
                last_we   = cyc;
                have_prev = 1;
                wr_cnt++;
                last_addr = MemWriteAddress;
                last_data = MemWriteData;
            end
            if (PcReset) begin
                pc_cnt++;
`ifndef CHECKSUM_EN
                chk(prev_we, "pcreset_after_write", prev_we, 1);
`endif
            end
            prev_we = MemWriteEn;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic start(input logic [6:0] n);
        @(posedge CLK); #1;
        LoadStart     = 1'b1;
        LoadWordCount = n;
        @(posedge CLK); #1;
        LoadStart     = 1'b0;
        LoadWordCount = '0;   // must already be latched
        model_sum     = '0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got;
        int n;
        got = 0; n = 0;
        ByteValid = 1'b1;
        ByteData  = b;
        do begin
            @(negedge CLK);
            got = ByteReady;
            @(posedge CLK); #1;
            n++;
        end while (!got && n < 200);
        if (!got) chk(0, "byte_accept_timeout", n, 200);
        ByteValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        do begin @(negedge CLK); n++; end while (Busy && n < bound);
        chk(!Busy, "load_done_timeout", n, bound);
    endtask

    task automatic push_word(input int w);
        exp_q.push_back({32'(w * 4),
                         img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]});
    endtask

    // Full legal load of img[0 .. 4n-1]; gap idles between bytes 1 and 2.
    task automatic run_load(input int n, input int gap);
        int pc0;
        pc0 = pc_cnt;
        start(7'(n));
        chk(LoadError == 1'b0, "err_clear_on_start", LoadError, 0);
        chk(Busy == 1'b1, "busy_after_start", Busy, 1);
        for (int w = 0; w < n; w++) begin
            push_word(w);
            for (int k = 0; k < 4; k++) begin
                send_byte(img[4*w+k]);
                model_sum = model_sum + img[4*w+k];
                if (k == 1 && gap > 0) idle(gap);
            end
        end
`ifdef CHECKSUM_EN
        send_byte(8'(8'd0 - model_sum));
`endif
        wait_idle(n * 30 + 50);
        chk(exp_q.size() == 0, "writes_outstanding", exp_q.size(), 0);
        chk(pc_cnt - pc0 == 1, "pcreset_count", pc_cnt - pc0, 1);
        chk(CpuStall == 1'b0, "released_after_load", CpuStall, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, pc0;

        // ---- reset state ----
        idle(2);
        chk(Busy == 0 && CpuStall == 0 && ByteReady == 0, "reset_status",
            {Busy, CpuStall, ByteReady}, 0);
        chk(MemWriteEn == 0 && PcReset == 0 && LoadError == 0, "reset_strobes",
            {MemWriteEn, PcReset, LoadError}, 0);
        chk(MemWriteData == 0 && MemWriteAddress == 0, "reset_data",
            {MemWriteAddress, MemWriteData}, 0);
        RST = 1'b0;
        mon_en = 1;
        idle(2);
        chk(Busy == 0 && CpuStall == 0, "idle_after_reset", {Busy, CpuStall}, 0);
        // bytes offered in IDLE are refused
        ByteValid = 1'b1; ByteData = 8'h55;
        @(negedge CLK);
        chk(ByteReady == 0, "no_ready_in_idle", ByteReady, 0);
        @(posedge CLK); #1; ByteValid = 1'b0;

        // ---- single word ----
        img[0] = 8'h13; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h20;
        run_load(1, 0);
        chk(last_data == 32'h2000_0013, "single_word_literal", last_data, 32'h2000_0013);
        chk(last_addr == 32'h0, "single_word_addr", last_addr, 0);

        // ---- three words with gaps ----
        img[0] = 8'h8C; img[1] = 8'h01; img[2] = 8'h00; img[3] = 8'h24;
        img[4] = 8'h11; img[5] = 8'h22; img[6] = 8'h33; img[7] = 8'h44;
        img[8] = 8'hAA; img[9] = 8'hBB; img[10] = 8'hCC; img[11] = 8'hDD;
        run_load(3, 3);
        chk(last_data == 32'hDDCC_BBAA, "three_word_literal", last_data, 32'hDDCCBBAA);
        chk(last_addr == 32'h8, "three_word_addr", last_addr, 8);
        idle(3);
        chk(MemWriteData == 32'hDDCC_BBAA, "data_holds", MemWriteData, 32'hDDCCBBAA);

        // ---- illegal counts ----
        wr0 = wr_cnt;
        start(7'd0);
        chk(LoadError == 1 && CpuStall == 1 && Busy == 0, "count0_error",
            {LoadError, CpuStall, Busy}, 3'b110);
        start(7'd101);
        chk(LoadError == 1 && CpuStall == 1 && Busy == 0, "count101_error",
            {LoadError, CpuStall, Busy}, 3'b110);
        idle(3);
        chk(CpuStall == 1, "stall_held_on_error", CpuStall, 1);
        chk(wr_cnt == wr0, "no_write_on_error", wr_cnt - wr0, 0);
        img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h03; img[3] = 8'h04;
        run_load(1, 0);   // checks that LoadError is cleared by the start

        // ---- LoadStart ignored during LOAD ----
        wr0 = wr_cnt; pc0 = pc_cnt;
        for (int i = 0; i < 8; i++) img[i] = 8'(8'hA0 + i);
        start(7'd2);
        push_word(0); push_word(1);
        send_byte(img[0]); send_byte(img[1]);
        LoadStart = 1'b1; LoadWordCount = 7'd5;
        @(posedge CLK); #1;
        LoadStart = 1'b0; LoadWordCount = '0;
        for (int i = 2; i < 8; i++) send_byte(img[i]);
`ifdef CHECKSUM_EN
        send_byte(8'(8'd0 - (8'hA0 + 8'hA1 + 8'hA2 + 8'hA3 + 8'hA4 + 8'hA5 + 8'hA6 + 8'hA7)));
`endif
        wait_idle(100);
        chk(wr_cnt - wr0 == 2, "restart_ignored_writes", wr_cnt - wr0, 2);
        chk(pc_cnt - pc0 == 1, "restart_ignored_pc", pc_cnt - pc0, 1);
        chk(last_data == 32'hA7A6_A5A4 && last_addr == 32'h4, "restart_ignored_word",
            {last_addr, last_data}, {32'h4, 32'hA7A6A5A4});
        chk(exp_q.size() == 0, "restart_ignored_queue", exp_q.size(), 0);

        // ---- maximum legal count ----
        for (int i = 0; i < 400; i++) img[i] = 8'(i * 7 + 3);
        run_load(100, 0);
        chk(last_addr == 32'd396, "max_count_last_addr", last_addr, 396);

        // ---- reset mid-stream ----
        wr0 = wr_cnt; pc0 = pc_cnt;
        start(7'd2);
        push_word(0);
        for (int i = 0; i < 6; i++) send_byte(img[i]);
        RST = 1'b1;
        #1;
        chk(Busy == 0 && CpuStall == 0 && ByteReady == 0, "midreset_status",
            {Busy, CpuStall, ByteReady}, 0);
        chk(MemWriteEn == 0 && PcReset == 0, "midreset_strobes", {MemWriteEn, PcReset}, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        have_prev = 0;
        idle(6);
        chk(wr_cnt - wr0 == 1, "midreset_writes", wr_cnt - wr0, 1);
        chk(pc_cnt == pc0, "midreset_no_pcreset", pc_cnt - pc0, 0);
        chk(exp_q.size() == 0, "midreset_queue", exp_q.size(), 0);

`ifdef CHECKSUM_EN
        // ---- checksum pass / fail ----
        img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h03; img[3] = 8'h04;
        pc0 = pc_cnt;
        start(7'd1);
        push_word(0);
        for (int i = 0; i < 4; i++) send_byte(img[i]);
        send_byte(8'hF6);
        wait_idle(50);
        chk(pc_cnt - pc0 == 1 && LoadError == 0, "checksum_pass",
            {pc_cnt - pc0, LoadError}, {32'd1, 1'b0});
        chk(last_data == 32'h0403_0201, "checksum_word", last_data, 32'h04030201);
        pc0 = pc_cnt;
        start(7'd1);
        push_word(0);
        for (int i = 0; i < 4; i++) send_byte(img[i]);
        send_byte(8'hF7);
        wait_idle(50);
        idle(3);
        chk(pc_cnt == pc0, "checksum_fail_no_pc", pc_cnt - pc0, 0);
        chk(LoadError == 1 && CpuStall == 1, "checksum_fail_err",
            {LoadError, CpuStall}, 2'b11);
`endif

        chk(exp_q.size() == 0, "final_queue", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
